// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_stage_reg
// Brief   : Pipeline stage register with optional two-entry skid buffer,
//           stall/flush control and a sticky halt flag.
// Revision: 1.0
// ============================================================================
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_hlt,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_hlt,
    output logic              halted,
    output logic [1:0]        occupancy
);

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [CTRL_W-1:0] r_out_ctrl;
    logic              r_out_hlt;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic              r_skid_hlt;
    logic              r_halted;

    logic w_in_ready;
    logic w_deliver;
    logic w_accept;
    logic w_out_free;

    assign w_deliver  = r_out_valid && out_ready && !stall && !flush;
    assign w_accept   = in_valid && w_in_ready;
    assign w_out_free = !r_out_valid || w_deliver;

    // Skid variant decouples in_ready from out_ready; the single-register
    // variant passes downstream backpressure straight through.
    generate
        if (SKID != 0) begin : g_skid
            assign w_in_ready = !r_skid_valid && !stall && !flush && !r_halted;
        end else begin : g_noskid
            assign w_in_ready = (!r_out_valid || out_ready) && !stall && !flush && !r_halted;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_ctrl   <= '0;
            r_out_hlt    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_ctrl  <= '0;
            r_skid_hlt   <= 1'b0;
            r_halted     <= 1'b0;
        end else if (flush) begin
            // Payload data is deliberately left in place; only control is squashed.
            r_out_valid  <= 1'b0;
            r_out_ctrl   <= '0;
            r_out_hlt    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
            r_skid_hlt   <= 1'b0;
        end else if (!stall) begin
            if (w_deliver && r_out_hlt) begin
                r_halted <= 1'b1;
            end
            if (w_out_free) begin
                if (r_skid_valid) begin
                    r_out_valid  <= 1'b1;
                    r_out_data   <= r_skid_data;
                    r_out_ctrl   <= r_skid_ctrl;
                    r_out_hlt    <= r_skid_hlt;
                    r_skid_valid <= 1'b0;
                    r_skid_ctrl  <= '0;
                    r_skid_hlt   <= 1'b0;
                end else if (w_accept) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= in_data;
                    r_out_ctrl  <= in_ctrl;
                    r_out_hlt   <= in_hlt;
                end else begin
                    r_out_valid <= 1'b0;
                    r_out_ctrl  <= '0;
                    r_out_hlt   <= 1'b0;
                end
            end else if (w_accept) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= in_data;
                r_skid_ctrl  <= in_ctrl;
                r_skid_hlt   <= in_hlt;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ctrl  = r_out_ctrl;
    assign out_hlt   = r_out_hlt;
    assign halted    = r_halted;
    assign occupancy = {1'b0, r_out_valid} + {1'b0, r_skid_valid};

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// Testbench for pipe_stage_reg: scoreboard-checked skid instance plus a
// directly checked single-register instance.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  c;
        logic        h;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush;
    logic        in_valid, in_hlt, out_ready;
    logic [31:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_ready, out_valid, out_hlt, halted;
    logic [31:0] out_data;
    logic [7:0]  out_ctrl;
    logic [1:0]  occupancy;

    logic        in_valid0, out_ready0;
    logic [31:0] in_data0;
    logic        in_ready0, out_valid0, out_hlt0, halted0;
    logic [31:0] out_data0;
    logic [7:0]  out_ctrl0;
    logic [1:0]  occupancy0;

    int tests = 0;
    int fails = 0;
    int delivered = 0;
    int accepted = 0;
    entry_t q[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_hlt(in_hlt),
        .stall(stall), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_hlt(out_hlt),
        .halted(halted), .occupancy(occupancy)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid0), .in_ready(in_ready0),
        .in_data(in_data0), .in_ctrl(8'h3C), .in_hlt(1'b0),
        .stall(stall), .flush(flush),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .out_data(out_data0), .out_ctrl(out_ctrl0), .out_hlt(out_hlt0),
        .halted(halted0), .occupancy(occupancy0)
    );

    // Scoreboard monitor: inputs settle 1 ns after each rising edge, so the
    // falling edge sees exactly what the next rising edge will act on.
    always @(negedge clk) begin
        entry_t e;
        if (!rst_n) begin
            q.delete();
        end else begin
            tests++;
            if (int'(occupancy) != q.size()) begin
                fails++;
                $display("FAIL occupancy: got %0d expected %0d", occupancy, q.size());
            end
            tests++;
            if ((stall || flush || halted) && in_ready) begin
                fails++;
                $display("FAIL in_ready_blocked: got 1 expected 0");
            end
            if (!out_valid) begin
                tests++;
                if (out_ctrl !== 8'h00 || out_hlt !== 1'b0) begin
                    fails++;
                    $display("FAIL bubble_ctrl: got ctrl=%h hlt=%b expected 00/0", out_ctrl, out_hlt);
                end
            end
            if (flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready && !stall) begin
                    delivered++;
                    tests++;
                    if (q.size() == 0) begin
                        fails++;
                        $display("FAIL deliver_unexpected: got data=%h expected none", out_data);
                    end else begin
                        e = q.pop_front();
                        if (out_data !== e.d || out_ctrl !== e.c || out_hlt !== e.h) begin
                            fails++;
                            $display("FAIL deliver: got %h/%h/%b expected %h/%h/%b",
                                     out_data, out_ctrl, out_hlt, e.d, e.c, e.h);
                        end
                    end
                end
                if (in_valid && in_ready) begin
                    accepted++;
                    q.push_back('{d: in_data, c: in_ctrl, h: in_hlt});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [7:0] c, input logic h);
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = c;
        in_hlt   = h;
        tick();
        in_valid = 1'b0;
        in_hlt   = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || halted !== 1'b0 || out_data !== 32'h0) begin
            fails++;
            $display("FAIL reset_state: got v=%b occ=%0d h=%b d=%h expected 0", out_valid, occupancy, halted, out_data);
        end
        tick();
        rst_n = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1 || in_ready0 !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b/%b expected 1/1", in_ready, in_ready0);
        end
        tick();
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h1111;
        in_ctrl   = 8'h11;
        tick();
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'h1111 || occupancy !== 2'd1) begin
            fails++;
            $display("FAIL stream_first: got v=%b d=%h occ=%0d expected 1/1111/1", out_valid, out_data, occupancy);
        end
        in_data = 32'h2222;
        in_ctrl = 8'h22;
        tick();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'h2222 || out_ctrl !== 8'h22 || occupancy !== 2'd1) begin
            fails++;
            $display("FAIL stream_second: got v=%b d=%h occ=%0d expected 1/2222/1", out_valid, out_data, occupancy);
        end
        tick();
        tests++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || out_data !== 32'h2222) begin
            fails++;
            $display("FAIL stream_bubble: got v=%b c=%h d=%h expected 0/00/2222", out_valid, out_ctrl, out_data);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(32'hA, 8'h0A, 1'b0);
        send(32'hB, 8'h0B, 1'b0);
        tests++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA) begin
            fails++;
            $display("FAIL bp_full: got occ=%0d rdy=%b d=%h expected 2/0/a", occupancy, in_ready, out_data);
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_no_comb_path: got in_ready=%b expected 0", in_ready);
        end
        tick();
        tests++;
        if (out_data !== 32'hB || occupancy !== 2'd1) begin
            fails++;
            $display("FAIL bp_drain1: got d=%h occ=%0d expected b/1", out_data, occupancy);
        end
        tick();
        tests++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_drain2: got occ=%0d v=%b expected 0/0", occupancy, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] next_d = 32'h100;
        logic        acc;
        int          acc0 = accepted;
        int          del0 = delivered;
        for (int i = 0; i < 60; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = next_d;
            in_ctrl   = next_d[7:0];
            #1;
            acc = in_valid && in_ready;
            tick();
            if (acc) next_d = next_d + 32'd1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5 && occupancy != 2'd0; i++) tick();
        tick();
        tests++;
        if ((delivered - del0) != (accepted - acc0) || occupancy !== 2'd0) begin
            fails++;
            $display("FAIL b2b_count: got delivered=%0d occ=%0d expected %0d/0",
                     delivered - del0, occupancy, accepted - acc0);
        end
    endtask

    task automatic test_stall_flush();
        out_ready = 1'b0;
        send(32'h33, 8'h5A, 1'b0);
        stall     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (out_valid !== 1'b1 || out_ctrl !== 8'h5A || out_data !== 32'h33 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold: got v=%b c=%h d=%h rdy=%b expected 1/5a/33/0",
                         out_valid, out_ctrl, out_data, in_ready);
            end
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        stall = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || occupancy !== 2'd0) begin
            fails++;
            $display("FAIL stall_flush: got v=%b c=%h occ=%0d expected 0/00/0", out_valid, out_ctrl, occupancy);
        end
    endtask

    task automatic test_halt();
        out_ready = 1'b1;
        send(32'h44, 8'h01, 1'b1);
        tests++;
        if (out_hlt !== 1'b1 || halted !== 1'b0) begin
            fails++;
            $display("FAIL halt_pending: got hlt=%b halted=%b expected 1/0", out_hlt, halted);
        end
        tick();
        tests++;
        if (halted !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL halt_set: got halted=%b rdy=%b expected 1/0", halted, in_ready);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        tests++;
        if (halted !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL halt_after_flush: got halted=%b rdy=%b expected 1/0", halted, in_ready);
        end
    endtask

    task automatic test_async_reset();
        int del0;
        pulse_reset();
        out_ready = 1'b0;
        send(32'h77, 8'h07, 1'b0);
        send(32'h88, 8'h08, 1'b0);
        tests++;
        if (occupancy !== 2'd2) begin
            fails++;
            $display("FAIL areset_setup: got occ=%0d expected 2", occupancy);
        end
        #2;
        rst_n = 1'b0;
        out_ready = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== 32'h0 ||
            out_ctrl !== 8'h00 || out_hlt !== 1'b0 || halted !== 1'b0) begin
            fails++;
            $display("FAIL areset_immediate: got v=%b occ=%0d d=%h c=%h expected all 0",
                     out_valid, occupancy, out_data, out_ctrl);
        end
        del0 = delivered;
        tick();
        rst_n = 1'b1;
        tests++;
        if (delivered != del0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL areset_no_deliver: got deliveries=%0d v=%b expected 0/0", delivered - del0, out_valid);
        end
        tick();
    endtask

    task automatic test_skid0();
        out_ready0 = 1'b0;
        in_valid0  = 1'b1;
        in_data0   = 32'h55;
        tick();
        tests++;
        if (out_valid0 !== 1'b1 || out_data0 !== 32'h55 || in_ready0 !== 1'b0) begin
            fails++;
            $display("FAIL skid0_load: got v=%b d=%h rdy=%b expected 1/55/0", out_valid0, out_data0, in_ready0);
        end
        in_data0 = 32'h66;
        tick();
        tests++;
        if (occupancy0 !== 2'd1 || out_data0 !== 32'h55) begin
            fails++;
            $display("FAIL skid0_hold: got occ=%0d d=%h expected 1/55", occupancy0, out_data0);
        end
        out_ready0 = 1'b1;
        #1;
        tests++;
        if (in_ready0 !== 1'b1) begin
            fails++;
            $display("FAIL skid0_comb_ready: got %b expected 1", in_ready0);
        end
        tick();
        in_valid0 = 1'b0;
        tests++;
        if (out_data0 !== 32'h66 || occupancy0 !== 2'd1 || out_ctrl0 !== 8'h3C) begin
            fails++;
            $display("FAIL skid0_replace: got d=%h occ=%0d c=%h expected 66/1/3c", out_data0, occupancy0, out_ctrl0);
        end
        tick();
        tests++;
        if (out_valid0 !== 1'b0 || occupancy0 !== 2'd0 || out_hlt0 !== 1'b0 || halted0 !== 1'b0) begin
            fails++;
            $display("FAIL skid0_drain: got v=%b occ=%0d expected 0/0", out_valid0, occupancy0);
        end
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; in_ctrl = '0; in_hlt = 1'b0; out_ready = 1'b0;
        in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b0;
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_back_to_back();
        test_stall_flush();
        test_halt();
        test_async_reset();
        test_skid0();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning payload width (data fields, held on bubble).
REQ-002 SHALL have parameter CTRL_W, default 8, meaning control width (write enables and selects, forced to zero on bubble).
REQ-003 SHALL have parameter SKID, default 1, meaning 1 = two-entry skid buffer and 0 = single register with combinational backpressure.
REQ-004 SHALL have clk  input  1  clock, rising edge.
REQ-005 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have in_valid  input  1, in_ready  output  1  upstream handshake.
REQ-007 SHALL have in_data  input  DATA_W, in_ctrl  input  CTRL_W, in_hlt  input  1  upstream payload.
REQ-008 SHALL have stall  input  1  global freeze, and flush  input  1  synchronous squash.
REQ-009 SHALL have out_valid  output  1, out_ready  input  1  downstream handshake.
REQ-010 SHALL have out_data  output  DATA_W, out_ctrl  output  CTRL_W, out_hlt  output  1  downstream payload.
REQ-011 SHALL have halted  output  1  sticky flag: a halt has been delivered downstream.
REQ-012 SHALL have occupancy  output  2  number of valid entries held (0..2).

Function
REQ-013 Accept SHALL occur when in_valid && in_ready at a rising edge; deliver SHALL occur when out_valid && out_ready at a rising edge.
REQ-014 in_ready SHALL be 0 whenever stall, flush or halted is 1.
REQ-015 With SKID=1, in_ready SHALL equal !skid_valid && !stall && !flush && !halted, as a registered term with no combinational path from out_ready.
REQ-016 With SKID=0, in_ready SHALL equal (!out_valid || out_ready) && !stall && !flush && !halted.
REQ-017 Latency SHALL be one cycle: an entry accepted at edge N with the output empty or delivering appears on the outputs after edge N.
REQ-018 With SKID=1, an accept while the output is full and not delivering SHALL load the skid entry; at the next deliver, the skid entry SHALL move to the output.
REQ-019 Ordering SHALL be strict FIFO; no entry SHALL be dropped or duplicated except by flush.
REQ-020 Accept and deliver in the same cycle SHALL keep occupancy unchanged and replace the output entry with the next entry.
REQ-021 stall=1 SHALL hold all state and outputs, ignore out_ready, and perform no deliver; out_valid SHALL remain visible.
REQ-022 flush=1 SHALL, at the next edge, clear all valid bits, set occupancy to 0, and zero out_ctrl and out_hlt.
REQ-023 flush SHALL take priority over stall, accept and deliver in the same cycle, and SHALL NOT clear halted.
REQ-024 When out_valid=0, out_ctrl SHALL be 0 and out_hlt SHALL be 0; out_data SHALL hold its last value.
REQ-025 halted SHALL set at the edge where a deliver occurs with out_hlt=1, and SHALL clear only on reset.
REQ-026 Entries already held when halted sets SHALL still drain normally.
REQ-027 occupancy SHALL equal the count of valid output and skid entries, and SHALL never exceed 1 when SKID=0.

Reset
REQ-028 rst_n=0 SHALL immediately clear out_valid, the skid valid bit, out_data, out_ctrl, out_hlt, halted and occupancy to 0, regardless of clk.
REQ-029 Reset asserted mid-transfer SHALL discard all held entries, and no deliver SHALL be reported in that cycle.
REQ-030 After rst_n deasserts, in_ready SHALL be 1 at the first edge when stall=0 and flush=0.

Verification
REQ-031 Stream test, SKID=1, out_ready=1: inputs 0x1111 then 0x2222 on consecutive cycles -> outputs appear on consecutive cycles, one-cycle latency, occupancy stays 1.
REQ-032 Backpressure test, SKID=1: out_ready=0, send 0xA, 0xB -> occupancy=2 and in_ready=0; then raise out_ready -> 0xA then 0xB delivered and occupancy returns to 0.
REQ-033 Stall-over-flush test: hold stall=1 for 3 cycles with out_valid=1, ctrl=0x5A -> outputs frozen; then flush=1 and stall=1 in the same cycle -> out_valid=0, out_ctrl=0x00, occupancy=0.
REQ-034 Halt test: deliver an entry with in_hlt=1 -> halted=1 at the next edge and in_ready=0 from then on; a following flush leaves halted=1.
REQ-035 Async reset test: assert rst_n=0 between clock edges while occupancy=2 -> all outputs 0 immediately, with no deliver seen on the next edge.
REQ-036 SKID=0 test: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle; toggling out_ready=1 -> in_ready=1 in the same cycle.
